// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU path between two requesters.
// Issues the winner's command, waits the pipeline latency and returns the result.
module alu_share_arbiter #(
    parameter int unsigned N      = 2,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned MODE_W = 2,
    parameter int unsigned LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [N-1:0]      a0,
    input  logic [N-1:0]      b0,
    input  logic [N-1:0]      a1,
    input  logic [N-1:0]      b1,
    input  logic [OP_W-1:0]   op0,
    input  logic [OP_W-1:0]   op1,
    input  logic [MODE_W-1:0] mode0,
    input  logic [MODE_W-1:0] mode1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [MODE_W-1:0] alu_mode,
    output logic              alu_issue,
    input  logic [6:0]        in_result,
    input  logic [6:0]        in_flags,
    output logic [6:0]        res_seg,
    output logic [6:0]        flags_seg,
    output logic              res_owner,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pick;

    logic               gnt0_d, gnt1_d, done0_d, done1_d, issue_d, busy_d;
    logic [N-1:0]       alu_a_d, alu_b_d;
    logic [OP_W-1:0]    alu_op_d;
    logic [MODE_W-1:0]  alu_mode_d;
    logic [SEG_W-1:0]   res_seg_d, flags_seg_d;
    logic               res_owner_d;

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_op_d    = alu_op;
        alu_mode_d  = alu_mode;
        res_seg_d   = res_seg;
        flags_seg_d = flags_seg;
        res_owner_d = res_owner;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        issue_d     = 1'b0;
        pick        = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    sel_d      = pick;
                    alu_a_d    = pick ? a1 : a0;
                    alu_b_d    = pick ? b1 : b0;
                    alu_op_d   = pick ? op1 : op0;
                    alu_mode_d = pick ? mode1 : mode0;
                    gnt0_d     = ~pick;
                    gnt1_d     = pick;
                    issue_d    = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    res_seg_d   = in_result;
                    flags_seg_d = in_flags;
                    res_owner_d = sel_q;
                    done0_d     = ~sel_q;
                    done1_d     = sel_q;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                last_d  = sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            alu_issue <= 1'b0;
            busy      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_mode  <= '0;
            res_seg   <= 7'h7F;
            flags_seg <= 7'h7F;
            res_owner <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            done0     <= done0_d;
            done1     <= done1_d;
            alu_issue <= issue_d;
            busy      <= busy_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_op    <= alu_op_d;
            alu_mode  <= alu_mode_d;
            res_seg   <= res_seg_d;
            flags_seg <= flags_seg_d;
            res_owner <= res_owner_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: LAT=2 instance for most scenarios,
// a LAT=5 instance on the same inputs for the latency scenario.
module tb_alu_share_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [1:0] a0, b0, a1, b1;
    logic [3:0] op0, op1;
    logic [1:0] mode0, mode1;
    logic [6:0] in_result, in_flags;

    logic       gnt0, gnt1, done0, done1, alu_issue, res_owner, busy;
    logic [1:0] alu_a, alu_b, alu_mode;
    logic [3:0] alu_op;
    logic [6:0] res_seg, flags_seg;

    logic       l5_gnt0, l5_gnt1, l5_done0, l5_done1, l5_alu_issue, l5_res_owner, l5_busy;
    logic [1:0] l5_alu_a, l5_alu_b, l5_alu_mode;
    logic [3:0] l5_alu_op;
    logic [6:0] l5_res_seg, l5_flags_seg;

    int n_checks = 0;
    int n_pass   = 0;

    alu_share_arbiter #(.N(2), .OP_W(4), .MODE_W(2), .LAT(2)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
        .mode0(mode0), .mode1(mode1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mode(alu_mode),
        .alu_issue(alu_issue), .in_result(in_result), .in_flags(in_flags),
        .res_seg(res_seg), .flags_seg(flags_seg), .res_owner(res_owner), .busy(busy)
    );

    alu_share_arbiter #(.N(2), .OP_W(4), .MODE_W(2), .LAT(5)) dut5 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
        .mode0(mode0), .mode1(mode1),
        .gnt0(l5_gnt0), .gnt1(l5_gnt1), .done0(l5_done0), .done1(l5_done1),
        .alu_a(l5_alu_a), .alu_b(l5_alu_b), .alu_op(l5_alu_op), .alu_mode(l5_alu_mode),
        .alu_issue(l5_alu_issue), .in_result(in_result), .in_flags(in_flags),
        .res_seg(l5_res_seg), .flags_seg(l5_flags_seg), .res_owner(l5_res_owner),
        .busy(l5_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int   ng;
        int   bad;
        int   cnt_g, cnt_d;
        int   gcyc[4];
        logic gwho[4];

        clk = 1'b0;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        op0 = '0; op1 = '0; mode0 = '0; mode1 = '0;
        in_result = 7'h11; in_flags = 7'h22;

        // Reset state
        do_reset();
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_gnt0",      32'(gnt0),      32'd0);
        check("rst_done0",     32'(done0),     32'd0);
        check("rst_issue",     32'(alu_issue), 32'd0);
        check("rst_alu_a",     32'(alu_a),     32'd0);
        check("rst_alu_op",    32'(alu_op),    32'd0);
        check("rst_res_seg",   32'(res_seg),   32'h7F);
        check("rst_flags_seg", 32'(flags_seg), 32'h7F);
        check("rst_owner",     32'(res_owner), 32'd0);

        // Single request from requester 0, LAT=2
        req0 = 1'b1; a0 = 2'b10; b0 = 2'b01; op0 = 4'b0001; mode0 = 2'b00;
        tick();
        check("t1_gnt0",  32'(gnt0),      32'd1);
        check("t1_gnt1",  32'(gnt1),      32'd0);
        check("t1_issue", 32'(alu_issue), 32'd1);
        check("t1_alu_a", 32'(alu_a),     32'h2);
        check("t1_alu_b", 32'(alu_b),     32'h1);
        check("t1_alu_op",32'(alu_op),    32'h1);
        req0 = 1'b0;
        tick();
        check("t1_gnt0_pulse", 32'(gnt0),      32'd0);
        check("t1_issue_pulse",32'(alu_issue), 32'd0);
        check("t1_busy",       32'(busy),      32'd1);
        in_result = 7'h24; in_flags = 7'h40;
        tick();
        check("t1_no_early_done", 32'(done0), 32'd0);
        tick();
        check("t1_done0",     32'(done0),     32'd1);
        check("t1_res_seg",   32'(res_seg),   32'h24);
        check("t1_flags_seg", 32'(flags_seg), 32'h40);
        check("t1_owner",     32'(res_owner), 32'd0);
        check("t1_alu_hold",  32'(alu_a),     32'h2);
        tick();
        check("t1_done_pulse", 32'(done0), 32'd0);
        check("t1_idle_busy",  32'(busy),  32'd0);

        // Both requests held: strict alternation, period LAT+3
        do_reset();
        a1 = 2'b01; op1 = 4'b0010;
        req0 = 1'b1; req1 = 1'b1;
        ng = 0; bad = 0;
        for (int c = 1; c <= 30 && ng < 4; c++) begin
            tick();
            if ((gnt0 && gnt1) || (done0 && done1)) bad++;
            if (gnt0 || gnt1) begin
                gwho[ng] = gnt1;
                gcyc[ng] = c;
                ng++;
            end
        end
        check("rr_grants", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) check("rr_order", 32'(gwho[i]), 32'(i % 2));
        for (int i = 1; i < 4; i++) check("rr_period", 32'(gcyc[i] - gcyc[i-1]), 32'd5);
        check("rr_overlap", 32'(bad), 32'd0);
        req0 = 1'b0; req1 = 1'b0;

        // req1 raised during WAIT of a requester-0 op
        do_reset();
        req0 = 1'b1;
        tick();
        check("t3_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        tick();
        req1 = 1'b1;
        tick();
        check("t3_no_gnt1_wait", 32'(gnt1), 32'd0);
        tick();
        check("t3_done0",        32'(done0), 32'd1);
        check("t3_no_gnt1_done", 32'(gnt1),  32'd0);
        tick();
        check("t3_no_gnt1_idle", 32'(gnt1),  32'd0);
        tick();
        check("t3_gnt1", 32'(gnt1),  32'd1);
        check("t3_alu_a",32'(alu_a), 32'h1);
        req1 = 1'b0;
        tick(); tick(); tick();
        check("t3_done1", 32'(done1),     32'd1);
        check("t3_owner", 32'(res_owner), 32'd1);

        // req1 pulsed for one cycle while busy is never served
        do_reset();
        req0 = 1'b1;
        tick();
        req0 = 1'b0; req1 = 1'b1;
        tick();
        req1 = 1'b0;
        cnt_g = 0; cnt_d = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (gnt1) cnt_g++;
            if (done1) cnt_d++;
        end
        check("t4_no_gnt1",  32'(cnt_g), 32'd0);
        check("t4_no_done1", 32'(cnt_d), 32'd0);
        check("t4_idle",     32'(busy),  32'd0);

        // Reset during WAIT abandons the op
        do_reset();
        in_result = 7'h30; in_flags = 7'h05;
        req0 = 1'b1; a0 = 2'b11;
        tick();
        req0 = 1'b0;
        tick();
        check("t5_wait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("t5_busy",    32'(busy),    32'd0);
        check("t5_done0",   32'(done0),   32'd0);
        check("t5_res_seg", 32'(res_seg), 32'h7F);
        check("t5_alu_a",   32'(alu_a),   32'd0);
        reset = 1'b0;
        cnt_d = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done0 || busy) cnt_d++;
        end
        check("t5_abandoned", 32'(cnt_d), 32'd0);
        req0 = 1'b1;
        tick();
        check("t5_regnt0", 32'(gnt0),  32'd1);
        check("t5_alu_a2", 32'(alu_a), 32'h3);
        req0 = 1'b0;
        tick(); tick(); tick();
        check("t5_redone0",  32'(done0),   32'd1);
        check("t5_res_seg2", 32'(res_seg), 32'h30);

        // LAT=5: done six cycles after issue, result sampled at issue+5
        do_reset();
        in_result = 7'h10;
        req0 = 1'b1;
        tick();
        check("t6_issue", 32'(l5_alu_issue), 32'd1);
        check("t6_gnt0",  32'(l5_gnt0),      32'd1);
        req0 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 5) check("t6_no_early_done", 32'(l5_done0), 32'd0);
            if (c == 6) begin
                check("t6_done0",   32'(l5_done0),   32'd1);
                check("t6_res_seg", 32'(l5_res_seg), 32'h15);
            end
            in_result = 7'(32'h10 + c);
        end
        tick();
        check("t6_done_pulse", 32'(l5_done0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Two-requester round-robin controller that shares the single registered ALU path (input register stage -> ALU_center -> output register stage) between two command sources, e.g. switch panel and a sequencer.
- Captures the winning requester's operands, opcode and mode, issues them to the ALU path, waits the fixed pipeline latency, then captures the seven-segment result and flags and returns them with a done pulse to the owner.
- Sits between the requesters and the ALU top level, driving its A/B/op/mode inputs.

Parameters:
- N, 2, operand width (A and B).
- OP_W, 4, opcode (operation button) width.
- MODE_W, 2, mode select width.
- LAT, 2, cycles from the issue cycle until the ALU result is valid at in_result/in_flags; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req0, req1  input  1 each  level request; held until the matching gnt pulse
- a0, b0 / a1, b1  input  N each  operands of requester 0 / 1
- op0 / op1  input  OP_W  opcode of requester 0 / 1
- mode0 / mode1  input  MODE_W  mode of requester 0 / 1
- gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured
- done0, done1  output  1 each  one-cycle completion pulse to the owner
- alu_a, alu_b  output  N  operands driven to the ALU path
- alu_op  output  OP_W  opcode to the ALU path
- alu_mode  output  MODE_W  mode to the ALU path
- alu_issue  output  1  high for exactly the issue cycle
- in_result, in_flags  input  7 each  seven-segment result and flags from the ALU path output registers
- res_seg, flags_seg  output  7 each  captured result and flags of the last completed op
- res_owner  output  1  requester index of the last completed op
- busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; gnt*, done*, alu_issue, busy, res_owner, alu_a, alu_b, alu_op, alu_mode = 0; res_seg = flags_seg = 7'h7F (all segments off, active-low); last-served pointer = 1, so requester 0 wins the first tie.
- FSM:
  - IDLE: sample req0/req1. Both low: stay. One high: select it. Both high: select the requester not equal to the last-served pointer. Next state ISSUE; latch the selected a/b/op/mode into alu_*.
  - ISSUE (one cycle): gnt<sel>=1, alu_issue=1, busy=1; alu_* valid. Load the wait counter with LAT-1. Next state WAIT.
  - WAIT: runs for exactly LAT cycles, counting down. On the final WAIT cycle, capture in_result -> res_seg, in_flags -> flags_seg and sel -> res_owner. Next state DONE.
  - DONE (one cycle): done<sel>=1; update last-served pointer to sel. Next state IDLE.
- alu_* hold their value from ISSUE until the next ISSUE, so the ALU input register stage sees stable data.
- Timing: request seen in IDLE at cycle k-1 gives issue at cycle k, result sampled at end of cycle k+LAT, done at cycle k+LAT+1. Back-to-back service period is LAT+3 cycles.
- Requests are sampled only in IDLE. A request raised while busy waits. A request dropped before its grant is never served and produces no pulses.
- A requester still holding req after its done is treated as a new request.
- Fairness: with both requests held continuously, grants strictly alternate 0,1,0,1...
- gnt0/gnt1 never high together; same for done0/done1.
- Reset asserted mid-operation: FSM returns to IDLE next edge. The in-flight op is abandoned with no done pulse, and all outputs take their reset values.
- Wait counter is 4 bits and never wraps, because LAT is at most 15.

Test Plan:
- Reset, then req0=1 with a0=2'b10, b0=2'b01, op0=4'b0001, mode0=2'b00, LAT=2: gnt0 one cycle after req is seen; alu_a=2'b10, alu_op=4'b0001 with alu_issue=1 that cycle; in_result=7'h24 and in_flags=7'h40 held from issue+2; done0 at issue+3 with res_seg=7'h24, flags_seg=7'h40, res_owner=0.
- req0 and req1 both high from reset and held: grant order 0,1,0,1. Each gnt is LAT+3=5 cycles apart; done0 and done1 never overlap.
- req1 raised while an op for requester 0 is in WAIT: no gnt1 until the FSM returns to IDLE; gnt1 exactly 2 cycles after done0.
- req1 pulsed for one cycle while busy: no gnt1, no done1, busy returns low after the current op completes.
- reset asserted during WAIT: next cycle busy=0, done*=0, res_seg=7'h7F, alu_a=0; a fresh req0 is served normally afterwards.
- LAT=5: done asserted exactly 6 cycles after alu_issue; res_seg equals in_result as sampled 5 cycles after issue, not any earlier value.
